// File: rtl/ddr_sched_pkg.sv
// Shared definitions for the DDR burst scheduler.
// Contents: FSM state encoding, cfg_data field layout, burst size helper.
// Optional feature macro used by the top: DDR_SCHED_PERF_EN.
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WEI_REQ,
    ST_WEI_WAIT,
    ST_FTM_REQ,
    ST_FTM_WAIT,
    ST_FIN
  } state_e;

  // cfg_data = {ftm_nb[15:0], ftm_addr[31:0], wei_nb[15:0], wei_addr[31:0]}
  localparam int CFG_W        = 96;
  localparam int CFG_ADDR_W   = 32;
  localparam int CFG_NB_W     = 16;
  localparam int WEI_ADDR_LSB = 0;
  localparam int WEI_NB_LSB   = 32;
  localparam int FTM_ADDR_LSB = 48;
  localparam int FTM_NB_LSB   = 80;

  function automatic int bytes_per_burst(input int burst_len, input int data_width);
    return burst_len * data_width / 8;
  endfunction

endpackage

// File: rtl/ddr_chunk_gen.sv
// Chunk generator for one DDR region (weights or feature map).
// Holds the running address, remaining burst count and round-robin unit
// select. latch_i loads a new region and clears cu_sel; advance_i consumes
// the current chunk.
// Ports: clk, rstn (async active-low), latch_i, addr_i, nb_i, advance_i,
//        chunk_o (bursts in current chunk), addr_o, cu_sel_o,
//        last_o (current chunk empties the region), empty_o (rem == 0).
module ddr_chunk_gen #(
  parameter int ADDR_WIDTH      = 32,
  parameter int UNIT_BURSTS     = 32,
  parameter int BYTES_PER_BURST = 128,
  parameter int N_CU            = 4,
  parameter int CU_W            = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  latch_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [15:0]           nb_i,
  input  logic                  advance_i,
  output logic [31:0]           chunk_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [CU_W-1:0]       cu_sel_o,
  output logic                  last_o,
  output logic                  empty_o
);

  localparam logic [31:0] UNIT = 32'(UNIT_BURSTS);
  localparam logic [31:0] BPB  = 32'(BYTES_PER_BURST);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           rem_q, rem_d;
  logic [CU_W-1:0]       cu_q, cu_d;
  logic [31:0]           rem_ext;
  logic [31:0]           step;

  assign rem_ext  = {16'b0, rem_q};
  assign chunk_o  = (rem_ext > UNIT) ? UNIT : rem_ext;
  // Byte step wraps with the address; no overflow reporting.
  assign step     = chunk_o * BPB;
  assign addr_o   = addr_q;
  assign cu_sel_o = cu_q;
  assign last_o   = (rem_ext <= UNIT);
  assign empty_o  = (rem_q == 16'd0);

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    cu_d   = cu_q;
    if (latch_i) begin
      addr_d = addr_i;
      rem_d  = nb_i;
      cu_d   = '0;
    end else if (advance_i) begin
      addr_d = addr_q + ADDR_WIDTH'(step);
      // chunk never exceeds rem, so its low 16 bits are the exact amount
      rem_d  = rem_q - chunk_o[15:0];
      cu_d   = (cu_q == CU_W'(N_CU - 1)) ? '0 : cu_q + CU_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      rem_q  <= '0;
      cu_q   <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      cu_q   <= cu_d;
    end
  end

endmodule

// File: rtl/ddr_burst_sched.sv
// DDR read scheduler: splits a layer descriptor into weight and feature-map
// chunks, issues them to the AXI read master and steers returned AXIS beats
// round-robin to the conv-unit weight/feature buffers.
// Ports: clk, rstn (async active-low); cfg_valid/cfg_ready/cfg_data
//        descriptor input; rd_start/rd_addr/rd_nbursts/rd_done read-master
//        handshake; s_axis_* read data; wb_full/wb_suff/fb_full buffer
//        status; wb_we/fb_we/mem_di buffer writes; busy, done status.
// Optional: DDR_SCHED_PERF_EN adds perf_stall and perf_bursts counters.
module ddr_burst_sched
  import ddr_sched_pkg::*;
#(
  parameter int N_CU            = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_LEN       = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int UNIT_BURSTS_WEI = 32,
  parameter int UNIT_BURSTS_FTM = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CFG_W-1:0]      cfg_data,
  output logic                  rd_start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_nbursts,
  input  logic                  rd_done,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  input  logic [N_CU-1:0]       wb_full,
  input  logic                  wb_suff,
  input  logic [N_CU-1:0]       fb_full,
  output logic [N_CU-1:0]       wb_we,
  output logic [N_CU-1:0]       fb_we,
  output logic [DATA_WIDTH-1:0] mem_di,
  output logic                  busy,
  output logic                  done
`ifdef DDR_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_stall,
  output logic [31:0]           perf_bursts
`endif
);

  localparam int CU_W = (N_CU > 1) ? $clog2(N_CU) : 1;
  localparam int BPB  = bytes_per_burst(BURST_LEN, DATA_WIDTH);

  state_e                state_q;
  logic                  rd_start_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [31:0]           rd_nbursts_q;
  logic                  done_q;

  logic                  accept;
  logic                  wei_wait, ftm_wait;
  logic                  wei_full, ftm_full, hs;
  logic [31:0]           wei_chunk, ftm_chunk;
  logic [ADDR_WIDTH-1:0] wei_addr, ftm_addr;
  logic [CU_W-1:0]       wei_cu, ftm_cu;
  logic                  wei_last, ftm_last, wei_empty, ftm_empty;
  logic [15:0]           cfg_wei_nb, cfg_ftm_nb;

  assign cfg_wei_nb = cfg_data[WEI_NB_LSB +: CFG_NB_W];
  assign cfg_ftm_nb = cfg_data[FTM_NB_LSB +: CFG_NB_W];
  assign accept     = (state_q == ST_IDLE) && cfg_valid;
  assign wei_wait   = (state_q == ST_WEI_WAIT);
  assign ftm_wait   = (state_q == ST_FTM_WAIT);

  ddr_chunk_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .UNIT_BURSTS(UNIT_BURSTS_WEI),
    .BYTES_PER_BURST(BPB), .N_CU(N_CU), .CU_W(CU_W)
  ) u_wei (
    .clk(clk), .rstn(rstn), .latch_i(accept),
    .addr_i(ADDR_WIDTH'(cfg_data[WEI_ADDR_LSB +: CFG_ADDR_W])),
    .nb_i(cfg_wei_nb), .advance_i(wei_wait && rd_done),
    .chunk_o(wei_chunk), .addr_o(wei_addr), .cu_sel_o(wei_cu),
    .last_o(wei_last), .empty_o(wei_empty)
  );

  ddr_chunk_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .UNIT_BURSTS(UNIT_BURSTS_FTM),
    .BYTES_PER_BURST(BPB), .N_CU(N_CU), .CU_W(CU_W)
  ) u_ftm (
    .clk(clk), .rstn(rstn), .latch_i(accept),
    .addr_i(ADDR_WIDTH'(cfg_data[FTM_ADDR_LSB +: CFG_ADDR_W])),
    .nb_i(cfg_ftm_nb), .advance_i(ftm_wait && rd_done),
    .chunk_o(ftm_chunk), .addr_o(ftm_addr), .cu_sel_o(ftm_cu),
    .last_o(ftm_last), .empty_o(ftm_empty)
  );

  // AXIS steering: only the unit currently selected for the active region
  // may back-pressure or receive beats.
  assign wei_full      = wb_full[wei_cu];
  assign ftm_full      = fb_full[ftm_cu];
  assign s_axis_tready = (wei_wait && !wei_full) || (ftm_wait && !ftm_full);
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign wb_we         = (hs && wei_wait) ? (N_CU'(1) << wei_cu) : '0;
  assign fb_we         = (hs && ftm_wait) ? (N_CU'(1) << ftm_cu) : '0;
  assign mem_di        = s_axis_tdata;

  assign cfg_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rd_start   = rd_start_q;
  assign rd_addr    = rd_addr_q;
  assign rd_nbursts = rd_nbursts_q;
  assign done       = done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      rd_start_q   <= 1'b0;
      rd_addr_q    <= '0;
      rd_nbursts_q <= '0;
      done_q       <= 1'b0;
    end else begin
      rd_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (cfg_wei_nb != 16'd0)      state_q <= ST_WEI_REQ;
            else if (cfg_ftm_nb != 16'd0) state_q <= ST_FTM_REQ;
            else                          state_q <= ST_FIN;
          end
        end
        ST_WEI_REQ: begin
          if (!wei_full) begin
            rd_start_q   <= 1'b1;
            rd_addr_q    <= wei_addr;
            rd_nbursts_q <= wei_chunk;
            state_q      <= ST_WEI_WAIT;
          end
        end
        // last/empty here describe the counts after this rd_done is applied
        ST_WEI_WAIT: begin
          if (rd_done) begin
            if (wei_last && ftm_empty)     state_q <= ST_FIN;
            else if (wb_suff && !ftm_empty) state_q <= ST_FTM_REQ;
            else if (!wei_last)            state_q <= ST_WEI_REQ;
            else                           state_q <= ST_FTM_REQ;
          end
        end
        ST_FTM_REQ: begin
          if (!ftm_full) begin
            rd_start_q   <= 1'b1;
            rd_addr_q    <= ftm_addr;
            rd_nbursts_q <= ftm_chunk;
            state_q      <= ST_FTM_WAIT;
          end
        end
        ST_FTM_WAIT: begin
          if (rd_done) begin
            if (wei_empty && ftm_last) state_q <= ST_FIN;
            else if (!ftm_last)        state_q <= ST_FTM_REQ;
            else                       state_q <= ST_WEI_REQ;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DDR_SCHED_PERF_EN
  logic [31:0] perf_stall_q, perf_bursts_q;
  logic [32:0] bursts_sum;

  assign bursts_sum  = {1'b0, perf_bursts_q} + {1'b0, rd_nbursts_q};
  assign perf_stall  = perf_stall_q;
  assign perf_bursts = perf_bursts_q;

  // Both counters saturate and restart with each accepted descriptor.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_q  <= '0;
      perf_bursts_q <= '0;
    end else if (accept) begin
      perf_stall_q  <= '0;
      perf_bursts_q <= '0;
    end else begin
      if ((wei_wait || ftm_wait) && s_axis_tvalid && !s_axis_tready &&
          (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (rd_start_q)
        perf_bursts_q <= bursts_sum[32] ? 32'hFFFF_FFFF : bursts_sum[31:0];
    end
  end
`endif

endmodule
